// File: rtl/booth_pp_accumulator.sv
// Sequential radix-4 Booth back end: one partial product per cycle, three digits, signed product.
// Optional BOOTH_CODE_CHECK_EN: treat codes 011/100/111 as illegal (contribute 0) and flag code_err.
module booth_pp_accumulator #(
  parameter int N  = 4,
  parameter int PW = N + 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  mcand,
  input  logic [2:0]    dig1,
  input  logic [2:0]    dig2,
  input  logic [2:0]    dig3,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] product
`ifdef BOOTH_CODE_CHECK_EN
  ,
  output logic          code_err
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [1:0]    k;
  logic [N-1:0]  mcand_q;
  logic [2:0]    dig1_q, dig2_q, dig3_q;
  logic [PW-1:0] acc;
  logic [PW-1:0] mcand_ext;
  logic [2:0]    dig_cur;
  logic [PW-1:0] pp;
  logic [PW-1:0] term;
  logic          accept;

  function automatic logic is_illegal(input logic [2:0] code);
    return (code == 3'b011) || (code == 3'b100) || (code == 3'b111);
  endfunction

  // Bitwise decode: magnitude from m2/m1, sign from s.
  function automatic logic [PW-1:0] pp_of(input logic [2:0] code, input logic [PW-1:0] mx);
    logic [PW-1:0] mag;
    mag = code[1] ? (mx << 1) : (code[0] ? mx : '0);
`ifdef BOOTH_CODE_CHECK_EN
    if (is_illegal(code)) mag = '0;
`endif
    return code[2] ? (~mag + 1'b1) : mag;
  endfunction

  assign mcand_ext = {{(PW-N){mcand_q[N-1]}}, mcand_q};
  assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
  assign busy      = (state == S_ACC);
  assign done      = (state == S_DONE);

  always_comb begin
    dig_cur = dig1_q;
    term    = '0;
    case (k)
      2'd0:    dig_cur = dig1_q;
      2'd1:    dig_cur = dig2_q;
      default: dig_cur = dig3_q;
    endcase
    pp = pp_of(dig_cur, mcand_ext);
    case (k)
      2'd0:    term = pp;
      2'd1:    term = pp << 2;
      default: term = pp << 4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      k       <= '0;
      acc     <= '0;
      product <= '0;
      mcand_q <= '0;
      dig1_q  <= '0;
      dig2_q  <= '0;
      dig3_q  <= '0;
    end else if (accept) begin
      state   <= S_ACC;
      k       <= '0;
      acc     <= '0;
      mcand_q <= mcand;
      dig1_q  <= dig1;
      dig2_q  <= dig2;
      dig3_q  <= dig3;
    end else begin
      case (state)
        S_ACC: begin
          if (k == 2'd2) begin
            product <= acc + term;
            state   <= S_DONE;
          end else begin
            acc <= acc + term;
            k   <= k + 2'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BOOTH_CODE_CHECK_EN
  // Sticky until reset or the next accept whose codes are all legal.
  always_ff @(posedge clk) begin
    if (!rst_n)
      code_err <= 1'b0;
    else if (accept)
      code_err <= is_illegal(dig1) || is_illegal(dig2) || is_illegal(dig3);
  end
`endif

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Directed self-checking bench for booth_pp_accumulator (N=4, PW=11); honours BOOTH_CODE_CHECK_EN.
module tb_booth_pp_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  mcand;
  logic [2:0]  dig1, dig2, dig3;
  logic        busy, done;
  logic [10:0] product;
`ifdef BOOTH_CODE_CHECK_EN
  logic        code_err;
`endif

  int checks = 0;
  int errors = 0;
  int n, nb;

  booth_pp_accumulator #(.N(4), .PW(11)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mcand   (mcand),
    .dig1    (dig1),
    .dig2    (dig2),
    .dig3    (dig3),
    .busy    (busy),
    .done    (done),
    .product (product)
`ifdef BOOTH_CODE_CHECK_EN
    ,
    .code_err(code_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a start for one cycle; returns at the negedge just after the accept edge.
  task automatic issue(input logic [3:0] m, input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    @(negedge clk);
    start = 1'b1; mcand = m; dig1 = a; dig2 = b; dig3 = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles (and busy cycles) from the post-accept negedge to done, bounded.
  task automatic wait_done();
    n = 0; nb = 0;
    while (!done && n < 20) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] m, input logic [2:0] a,
                        input logic [2:0] b, input logic [2:0] c, input logic [10:0] exp);
    issue(m, a, b, c);
    wait_done();
    check({tag, "_latency"}, n, 3);
    check({tag, "_busy_cycles"}, nb, 3);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_product"}, product, exp);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mcand = '0; dig1 = '0; dig2 = '0; dig3 = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_product", product, 0);
`ifdef BOOTH_CODE_CHECK_EN
    check("reset_code_err", code_err, 0);
`endif
    rst_n = 1'b1;

    // 5 * (+6) = 30
    run_op("pos6", 4'd5, 3'b110, 3'b010, 3'b000, 11'h01E);
    // -8 * (-3) = 24
    run_op("neg3", 4'h8, 3'b001, 3'b101, 3'b000, 11'h018);
    // -8 * (-42) = 336 ; 7 * (-42) = -294
    run_op("worst_m8", 4'h8, 3'b110, 3'b110, 3'b110, 11'h150);
    run_op("worst_p7", 4'd7, 3'b110, 3'b110, 3'b110, 11'h6DA);

    // Reset mid-accumulation discards the partial result.
    issue(4'd5, 3'b110, 3'b010, 3'b000);
    check("mid_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_product", product, 0);
    rst_n = 1'b1;
    run_op("after_rst", 4'd7, 3'b001, 3'b001, 3'b000, 11'h023);

    // Start held high through ACC with operands changing: ignored.
    @(negedge clk);
    start = 1'b1; mcand = 4'd5; dig1 = 3'b110; dig2 = 3'b010; dig3 = 3'b000;
    @(negedge clk);
    mcand = 4'd7; dig1 = 3'b110; dig2 = 3'b110; dig3 = 3'b110;
    wait_done();
    start = 1'b0;
    check("hold_latency", n, 3);
    check("hold_product", product, 11'h01E);
    @(negedge clk);
    check("hold_idle_done", done, 0);
    check("hold_idle_busy", busy, 0);

    // Back-to-back: start during DONE.
    issue(4'd5, 3'b110, 3'b010, 3'b000);
    wait_done();
    check("b2b_first_product", product, 11'h01E);
    start = 1'b1; mcand = 4'd3; dig1 = 3'b001; dig2 = 3'b000; dig3 = 3'b000;
    @(negedge clk);
    start = 1'b0;
    check("b2b_done_dropped", done, 0);
    check("b2b_busy", busy, 1);
    wait_done();
    check("b2b_gap", n + 1, 4);
    check("b2b_product", product, 11'h003);

    // Illegal code 011 in dig1, mcand 5.
    issue(4'd5, 3'b011, 3'b000, 3'b000);
    wait_done();
    check("illegal_latency", n, 3);
`ifdef BOOTH_CODE_CHECK_EN
    check("illegal_product", product, 11'h000);
    check("illegal_code_err", code_err, 1);
    issue(4'd2, 3'b001, 3'b000, 3'b000);
    check("legal_clears_code_err", code_err, 0);
    wait_done();
    check("legal_after_illegal_product", product, 11'h002);
`else
    check("illegal_product", product, 11'h00A);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_pp_accumulator.md
Name: booth_pp_accumulator

Overview:
- Sequential radix-4 Booth multiplier back end, directly downstream of the Booth recoder.
- Takes the recoder's three 3-bit digit codes plus a signed multiplicand.
- Forms one partial product per cycle (0, ±1x, ±2x multiplicand), shifts it by 2 bits per digit position, and accumulates.
- Presents the signed product with a start/busy/done handshake.

Parameters:
- N, 4: multiplicand width, signed two's complement.
- PW, N+7: product width. Holds the worst case |mcand| × 42. Must not be overridden below N+7.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  in  1  request. Sampled only in IDLE or DONE.
- mcand  in  N  signed multiplicand. Latched when start is accepted.
- dig1  in  3  digit code, weight 4^0.
- dig2  in  3  digit code, weight 4^1.
- dig3  in  3  digit code, weight 4^2. All digits latched when start is accepted.
- busy  out  1  high while accumulating.
- done  out  1  one-cycle pulse; product valid.
- product  out  PW  signed result. Held until the next completion.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Digit code {s,m2,m1}:
  - 000 = 0
  - 001 = +1
  - 010 = +2
  - 101 = -1
  - 110 = -2
- Default decode for all other codes:
  - magnitude = m2 ? 2x : (m1 ? 1x : 0)
  - negate when s = 1
  - Hence 011 = +2, 100 = 0, 111 = -2.
- Partial product:
  - Sign-extend mcand to PW bits.
  - Apply ×2 as a left shift by 1.
  - Negate in two's complement.
  - Shift left by 2k for digit k = 0, 1, 2.
  - All arithmetic is modulo 2^PW. No overflow is possible for PW ≥ N+7.
- Reset (rst_n = 0 at an edge):
  - state = IDLE, busy = 0, done = 0, product = 0.
  - Accumulator, digit index and latched operands = 0.
  - Applies in any state, including mid-accumulation. The partial result is discarded.
- States: IDLE, ACC, DONE.
  - IDLE: busy = 0, done = 0. On start = 1: latch mcand and dig1..3, acc = 0, k = 0, go to ACC.
  - ACC: busy = 1. Each cycle, acc += pp(dig_k+1) << 2k and k increments.
    - When k = 2, product <= acc + pp(dig3) << 4 and go to DONE.
    - start is ignored in ACC.
  - DONE: done = 1, busy = 0, product stable.
    - start = 1: accept a new operation (latch operands, go to ACC). Back-to-back issue is allowed.
    - Otherwise go to IDLE.
- Latency:
  - start is sampled at edge E0.
  - Digits are added at E1, E2 and E3.
  - done = 1 during the cycle after E3.
  - Throughput is one product per 4 cycles with back-to-back start.
- Inputs may change freely after the accept edge; latched copies are used.
- done is a registered output and never asserts together with busy.

Optional Feature:
- Macro: BOOTH_CODE_CHECK_EN.
- Defined:
  - Codes 011, 100 and 111 are illegal. Each contributes 0 to the accumulator.
  - Adds output port code_err (1 bit, reset 0). It sets sticky when an illegal code is latched at accept.
  - code_err is cleared only by reset or by the next accepted start with all-legal codes.
- Undefined:
  - No code_err port.
  - Illegal codes use the default bitwise decode (011 = +2, 100 = 0, 111 = -2).

Test Plan:
- Reset: assert rst_n = 0 mid-ACC -> next cycle busy = 0, done = 0, product = 0, state IDLE. A start one cycle after release completes normally.
- Multiplier +6, mcand = 5: start with dig1 = 110, dig2 = 010, dig3 = 000 -> done 3 cycles after the accept edge, product = 30 (0x01E). busy is high for exactly 3 cycles.
- Multiplier -3, mcand = -8: start with dig1 = 001, dig2 = 101, dig3 = 000 -> product = 24 (0x018).
- Worst case, mcand = -8: start with dig1 = dig2 = dig3 = 110 -> product = 336 (0x150). Also mcand = 7 with the same digits -> product = -294 (0x6DA).
- Handshake:
  - Hold start high during ACC and change the operands -> ignored; the result matches the first operands.
  - Assert start during DONE with mcand = 3 and digits 001/000/000 -> accepted. The second done pulse comes 4 cycles after the first, with product = 3.
- Illegal code: dig1 = 011, dig2 = 000, dig3 = 000, mcand = 5.
  - With BOOTH_CODE_CHECK_EN: product = 0, code_err = 1, cleared by the next legal start.
  - Without it: product = 10.
